// File: rtl/pixel_write_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM framebuffer write port between pixel cores.
// Optional PIXEL_ARB_STATS_EN adds saturating stat_writes / stat_drops counters.
module pixel_write_arbiter #(
    parameter int CORES_COUNT   = 10,
    parameter int COLOR_WIDTH   = 16,
    parameter int BUFFER_ADDR_W = 32,
    parameter int REGION_BYTES  = 192000,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     frame_eoc,
    input  logic [BUFFER_ADDR_W-1:0] fb_base,
    input  logic [COLOR_WIDTH-1:0]   ppu_data    [CORES_COUNT],
    input  logic [BUFFER_ADDR_W-1:0] ppu_address [CORES_COUNT],
    input  logic [CORES_COUNT-1:0]   ppu_valid,
    output logic                     stall,
    output logic                     overflow,
    output logic                     frame_done,
    output logic [BUFFER_ADDR_W-1:0] avm_address,
    output logic [COLOR_WIDTH-1:0]   avm_writedata,
    output logic                     avm_write,
    input  logic                     avm_waitrequest
`ifdef PIXEL_ARB_STATS_EN
    ,
    output logic [31:0]              stat_writes,
    output logic [31:0]              stat_drops
`endif
);

    localparam int IDX_W = (CORES_COUNT > 1) ? $clog2(CORES_COUNT) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, ISSUE} state_e;

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         grant_q, grant_d;
    logic [IDX_W-1:0]         rr_q, rr_d;
    logic [BUFFER_ADDR_W-1:0] fb_base_q, fb_base_d;
    logic [BUFFER_ADDR_W-1:0] avm_address_q, avm_address_d;
    logic [COLOR_WIDTH-1:0]   avm_writedata_q, avm_writedata_d;
    logic                     avm_write_q, avm_write_d;
    logic                     overflow_q, overflow_d;
    logic                     pending_q, pending_d;

    logic [BUFFER_ADDR_W-1:0] mem_addr_q [CORES_COUNT][FIFO_DEPTH];
    logic [BUFFER_ADDR_W-1:0] mem_addr_d [CORES_COUNT][FIFO_DEPTH];
    logic [COLOR_WIDTH-1:0]   mem_data_q [CORES_COUNT][FIFO_DEPTH];
    logic [COLOR_WIDTH-1:0]   mem_data_d [CORES_COUNT][FIFO_DEPTH];
    logic [PTR_W-1:0]         wptr_q [CORES_COUNT], wptr_d [CORES_COUNT];
    logic [PTR_W-1:0]         rptr_q [CORES_COUNT], rptr_d [CORES_COUNT];
    logic [CNT_W-1:0]         cnt_q  [CORES_COUNT], cnt_d  [CORES_COUNT];

    logic [CORES_COUNT-1:0]   nonempty, pop, drop;
    logic                     stall_c, frame_done_c;
    logic [IDX_W-1:0]         next_rr, base, sel;
    logic                     found, accept, go;

    always_comb begin
        nonempty = '0;
        stall_c  = 1'b0;
        for (int i = 0; i < CORES_COUNT; i++) begin
            nonempty[i] = (cnt_q[i] != '0);
            if (cnt_q[i] >= CNT_W'(FIFO_DEPTH - 1))
                stall_c = 1'b1;
        end
    end

    // Search starts after the last granted core once a write is accepted,
    // wrapping so the same core can be re-granted if it is the only one left.
    always_comb begin
        int idx;
        idx     = 0;
        next_rr = (int'(grant_q) == CORES_COUNT - 1) ? '0 : grant_q + 1'b1;
        base    = (state_q == ISSUE) ? next_rr : rr_q;
        found   = 1'b0;
        sel     = '0;
        for (int k = 0; k < CORES_COUNT; k++) begin
            idx = int'(base) + k;
            if (idx >= CORES_COUNT)
                idx = idx - CORES_COUNT;
            if (!found && nonempty[idx]) begin
                found = 1'b1;
                sel   = IDX_W'(idx);
            end
        end
    end

    assign accept = (state_q == ISSUE) && !avm_waitrequest;
    assign go     = found && ((state_q == IDLE) || accept);

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        rr_d            = rr_q;
        avm_address_d   = avm_address_q;
        avm_writedata_d = avm_writedata_q;
        avm_write_d     = avm_write_q;
        pop             = '0;
        if (accept)
            rr_d = next_rr;
        if (go) begin
            state_d         = ISSUE;
            grant_d         = sel;
            pop[sel]        = 1'b1;
            avm_address_d   = mem_addr_q[sel][rptr_q[sel]];
            avm_writedata_d = mem_data_q[sel][rptr_q[sel]];
            avm_write_d     = 1'b1;
        end else if (accept) begin
            state_d     = IDLE;
            avm_write_d = 1'b0;
        end
    end

    always_comb begin
        logic full, do_push;
        full     = 1'b0;
        do_push  = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q;
        drop       = '0;
        for (int i = 0; i < CORES_COUNT; i++) begin
            full    = (cnt_q[i] == CNT_W'(FIFO_DEPTH));
            do_push = ppu_valid[i] && (!full || pop[i]);
            drop[i] = ppu_valid[i] && full && !pop[i];
            if (do_push) begin
                mem_addr_d[i][wptr_q[i]] = fb_base_q
                    + BUFFER_ADDR_W'(64'(i) * 64'(REGION_BYTES))
                    + ppu_address[i];
                mem_data_d[i][wptr_q[i]] = ppu_data[i];
                wptr_d[i] = wptr_q[i] + 1'b1;
            end
            if (pop[i])
                rptr_d[i] = rptr_q[i] + 1'b1;
            if (do_push && !pop[i])
                cnt_d[i] = cnt_q[i] + 1'b1;
            else if (!do_push && pop[i])
                cnt_d[i] = cnt_q[i] - 1'b1;
        end
    end

    assign frame_done_c = pending_q && !(|nonempty) && !avm_write_q;

    always_comb begin
        fb_base_d  = start ? fb_base : fb_base_q;
        overflow_d = overflow_q;
        if (|drop)
            overflow_d = 1'b1;
        else if (start)
            overflow_d = 1'b0;
        pending_d = pending_q;
        if (frame_eoc)
            pending_d = 1'b1;
        else if (start || frame_done_c)
            pending_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            grant_q         <= '0;
            rr_q            <= '0;
            fb_base_q       <= '0;
            avm_address_q   <= '0;
            avm_writedata_q <= '0;
            avm_write_q     <= 1'b0;
            overflow_q      <= 1'b0;
            pending_q       <= 1'b0;
            for (int i = 0; i < CORES_COUNT; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
                for (int j = 0; j < FIFO_DEPTH; j++) begin
                    mem_addr_q[i][j] <= '0;
                    mem_data_q[i][j] <= '0;
                end
            end
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            rr_q            <= rr_d;
            fb_base_q       <= fb_base_d;
            avm_address_q   <= avm_address_d;
            avm_writedata_q <= avm_writedata_d;
            avm_write_q     <= avm_write_d;
            overflow_q      <= overflow_d;
            pending_q       <= pending_d;
            wptr_q          <= wptr_d;
            rptr_q          <= rptr_d;
            cnt_q           <= cnt_d;
            mem_addr_q      <= mem_addr_d;
            mem_data_q      <= mem_data_d;
        end
    end

    assign stall         = stall_c;
    assign overflow      = overflow_q;
    assign frame_done    = frame_done_c;
    assign avm_address   = avm_address_q;
    assign avm_writedata = avm_writedata_q;
    assign avm_write     = avm_write_q;

`ifdef PIXEL_ARB_STATS_EN
    logic [31:0] stat_writes_q, stat_writes_d;
    logic [31:0] stat_drops_q, stat_drops_d;

    always_comb begin
        logic [31:0] drop_n;
        logic [32:0] sum;
        drop_n = '0;
        for (int i = 0; i < CORES_COUNT; i++)
            drop_n = drop_n + 32'(drop[i]);
        stat_writes_d = start ? '0 : stat_writes_q;
        if (accept && stat_writes_d != '1)
            stat_writes_d = stat_writes_d + 1'b1;
        sum          = {1'b0, (start ? 32'd0 : stat_drops_q)} + {1'b0, drop_n};
        stat_drops_d = sum[32] ? '1 : sum[31:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_writes_q <= '0;
            stat_drops_q  <= '0;
        end else begin
            stat_writes_q <= stat_writes_d;
            stat_drops_q  <= stat_drops_d;
        end
    end

    assign stat_writes = stat_writes_q;
    assign stat_drops  = stat_drops_q;
`endif

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Scoreboard bench for pixel_write_arbiter: expected writes queued at drive time,
// compared as the Avalon port accepts them.
module tb_pixel_write_arbiter;

    localparam int C  = 10;
    localparam int CW = 16;
    localparam int AW = 32;
    localparam int RB = 192000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, frame_eoc;
    logic [AW-1:0] fb_base;
    logic [CW-1:0] ppu_data [C];
    logic [AW-1:0] ppu_address [C];
    logic [C-1:0]  ppu_valid;
    logic          stall, overflow, frame_done;
    logic [AW-1:0] avm_address;
    logic [CW-1:0] avm_writedata;
    logic          avm_write, avm_waitrequest;
`ifdef PIXEL_ARB_STATS_EN
    logic [31:0]   stat_writes, stat_drops;
`endif

    pixel_write_arbiter dut (
        .clk             (clk),
        .reset_n         (rst_n),
        .start           (start),
        .frame_eoc       (frame_eoc),
        .fb_base         (fb_base),
        .ppu_data        (ppu_data),
        .ppu_address     (ppu_address),
        .ppu_valid       (ppu_valid),
        .stall           (stall),
        .overflow        (overflow),
        .frame_done      (frame_done),
        .avm_address     (avm_address),
        .avm_writedata   (avm_writedata),
        .avm_write       (avm_write),
        .avm_waitrequest (avm_waitrequest)
`ifdef PIXEL_ARB_STATS_EN
        ,
        .stat_writes     (stat_writes),
        .stat_drops      (stat_drops)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_acc   = 0;
    int last_acc_cyc = 0;
    int n_done  = 0;
    int done_cyc = 0;
    logic [AW+CW-1:0] sb [$];
    logic [AW-1:0] base_q;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n && avm_write && !avm_waitrequest) begin
            if (sb.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                logic [AW+CW-1:0] e;
                e = sb.pop_front();
                check("avm_address", avm_address, e[AW+CW-1:CW]);
                check("avm_writedata", avm_writedata, e[CW-1:0]);
            end
            n_acc++;
            last_acc_cyc = cyc;
        end
        if (rst_n && frame_done) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    function automatic logic [AW-1:0] exp_addr(input int core,
                                               input logic [AW-1:0] off);
        return base_q + AW'(core * RB) + off;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        base_q = '0;
    endtask

    task automatic do_start(input logic [AW-1:0] base);
        @(posedge clk);
        #1 start = 1'b1;
        fb_base = base;
        @(posedge clk);
        #1 start = 1'b0;
        base_q = base;
    endtask

    task automatic wait_first_write(input int t0, input int lat);
        int n;
        n = 0;
        while (!avm_write && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("latency", cyc - t0, lat);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || avm_write) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", n >= 60, 0);
    endtask

    initial begin
        int t0, a0;
        start = 0; frame_eoc = 0; fb_base = '0;
        ppu_valid = '0; avm_waitrequest = 1'b0;
        for (int i = 0; i < C; i++) begin
            ppu_data[i] = '0;
            ppu_address[i] = '0;
        end
        do_reset();

        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle_outputs", {avm_write, stall, overflow, frame_done}, 4'b0);
        end

        // single write, fixed address example
        do_start(32'h1000);
        @(posedge clk);
        #1 ppu_valid[2] = 1'b1;
        ppu_data[2] = 16'hBEEF;
        ppu_address[2] = 32'h8;
        sb.push_back({32'h0005_EC08, 16'hBEEF});
        t0 = cyc;
        @(posedge clk);
        #1 ppu_valid[2] = 1'b0;
        wait_first_write(t0, 2);
        wait_drain();

        // all cores at once from a fresh rr pointer
        do_reset();
        do_start(32'h0010_0000);
        @(posedge clk);
        #1;
        for (int i = 0; i < C; i++) begin
            ppu_valid[i] = 1'b1;
            ppu_data[i] = CW'(16'h0100 + i);
            ppu_address[i] = AW'(i * 4);
            sb.push_back({exp_addr(i, AW'(i * 4)), CW'(16'h0100 + i)});
        end
        t0 = cyc;
        a0 = n_acc;
        @(posedge clk);
        #1 ppu_valid = '0;
        wait_first_write(t0, 2);
        t0 = cyc;
        wait_drain();
        check("burst_count", n_acc - a0, 10);
        check("burst_back_to_back", last_acc_cyc - t0, 9);
        @(negedge clk);
        check("burst_idle", avm_write, 0);

        // core 0 floods its FIFO under backpressure
        avm_waitrequest = 1'b1;
        do_start(32'h2000_0000);
        a0 = n_acc;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1 ppu_valid[0] = 1'b1;
            ppu_data[0] = CW'(16'hA000 + k);
            ppu_address[0] = AW'(k * 4);
            if (k < 5)
                sb.push_back({exp_addr(0, AW'(k * 4)), CW'(16'hA000 + k)});
            @(negedge clk);
            check("stall", stall, k >= 4);
            check("overflow", overflow, k >= 6);
        end
        @(posedge clk);
        #1 ppu_valid = '0;
        frame_eoc = 1'b1;
        n_done = 0;
        @(posedge clk);
        #1 frame_eoc = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_address", avm_address, exp_addr(0, 0));
        check("no_early_done", n_done, 0);
        @(posedge clk);
        #1 avm_waitrequest = 1'b0;
        wait_drain();
        repeat (4) @(negedge clk);
        check("flood_writes", n_acc - a0, 5);
        check("done_once", n_done, 1);
        check("done_timing", done_cyc, last_acc_cyc + 1);
        check("stall_after", stall, 0);
        check("overflow_sticky", overflow, 1);
`ifdef PIXEL_ARB_STATS_EN
        check("stat_writes", stat_writes, 5);
        check("stat_drops", stat_drops, 3);
`endif

        // start clears overflow; address wraps mod 2^32
        do_start(32'hFFFF_FFF0);
        @(negedge clk);
        check("overflow_cleared", overflow, 0);
        @(posedge clk);
        #1 ppu_valid[9] = 1'b1;
        ppu_data[9] = 16'h1234;
        ppu_address[9] = 32'h20;
        sb.push_back({AW'(33'h0_FFFF_FFF0 + 33'(9 * RB) + 33'h20), 16'h1234});
        @(posedge clk);
        #1 ppu_valid = '0;
        wait_drain();

        // reset mid-write drops avm_write and discards queued pixels
        avm_waitrequest = 1'b1;
        @(posedge clk);
        #1 ppu_valid[1] = 1'b1;
        ppu_valid[4] = 1'b1;
        @(posedge clk);
        #1 ppu_valid = '0;
        repeat (2) @(negedge clk);
        check("write_pending", avm_write, 1);
        #2 rst_n = 1'b0;
        #1 check("async_drop", avm_write, 0);
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        avm_waitrequest = 1'b0;
        a0 = n_acc;
        repeat (6) @(negedge clk);
        check("queue_lost", n_acc - a0, 0);
        check("post_reset", {avm_write, stall, overflow}, 3'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
